// File: rtl/lif_pkg.sv
// Shared widths, threshold, FSM state encoding and saturation helper for the LIF layer scheduler.
package lif_pkg;

   localparam int               DEF_INPUT_WIDTH   = 8;
   localparam int               DEF_VOLTAGE_WIDTH = 16;
   localparam int               DEF_FRAC_BITS     = 8;
   localparam logic [15:0]      DEF_THRESHOLD     = 16'h0100;

   typedef logic [1:0] lif_state_t;
   localparam lif_state_t IDLE  = 2'd0;
   localparam lif_state_t RUN   = 2'd1;
   localparam lif_state_t DRAIN = 2'd2;

   // Signed add of two sign-extended operands, clamped to a width-bit signed range.
   function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b,
                                                  input int width);
      logic signed [32:0] s;
      logic signed [32:0] hi;
      logic signed [32:0] lo;
      s  = {a[31], a} + {b[31], b};
      hi = (33'sd1 <<< (width - 1)) - 33'sd1;
      lo = -(33'sd1 <<< (width - 1));
      if (s > hi) begin
         return hi[31:0];
      end else if (s < lo) begin
         return lo[31:0];
      end else begin
         return s[31:0];
      end
   endfunction

endpackage

// File: rtl/lif_update_core.sv
// Combinational LIF neuron update: leak, input integration, saturation, fire compare and reset.
// LIF_SOFT_RESET_EN selects subtractive reset on fire; otherwise the potential is zeroed.
module lif_update_core
   import lif_pkg::*;
#(
   parameter int                         INPUT_WIDTH   = DEF_INPUT_WIDTH,
   parameter int                         VOLTAGE_WIDTH = DEF_VOLTAGE_WIDTH,
   parameter logic [VOLTAGE_WIDTH-1:0]   THRESHOLD     = VOLTAGE_WIDTH'(DEF_THRESHOLD)
)(
   input  logic signed [VOLTAGE_WIDTH-1:0] v_stored,
   input  logic                            t0,
   input  logic signed [INPUT_WIDTH-1:0]   in_current,
   output logic signed [VOLTAGE_WIDTH-1:0] v_new,
   output logic                            spike
);

   logic signed [VOLTAGE_WIDTH-1:0] v;
   logic signed [VOLTAGE_WIDTH-1:0] leaked;

   // Fire decision uses the potential before this step's input (fire-then-reset).
   always_comb begin
      v      = t0 ? {VOLTAGE_WIDTH{1'b0}} : v_stored;
      leaked = v - (v >>> 2);
      spike  = (v > $signed(THRESHOLD));
      if (spike) begin
`ifdef LIF_SOFT_RESET_EN
         v_new = VOLTAGE_WIDTH'(sat_add(32'(v), -32'($signed(THRESHOLD)), VOLTAGE_WIDTH));
`else
         v_new = {VOLTAGE_WIDTH{1'b0}};
`endif
      end else begin
         v_new = VOLTAGE_WIDTH'(sat_add(32'(leaked), 32'(in_current), VOLTAGE_WIDTH));
      end
   end

endmodule

// File: rtl/lif_layer_scheduler.sv
// Time-multiplexed LIF layer controller: FSM, neuron/timestep counters, potential memory, handshakes.
// Optional feature macro LIF_SOFT_RESET_EN is consumed by lif_update_core.
module lif_layer_scheduler
   import lif_pkg::*;
#(
   parameter int                         INPUT_WIDTH       = DEF_INPUT_WIDTH,
   parameter int                         VOLTAGE_WIDTH     = DEF_VOLTAGE_WIDTH,
   parameter int                         VOLTAGE_FRAC_BITS = DEF_FRAC_BITS,
   parameter logic [VOLTAGE_WIDTH-1:0]   THRESHOLD         = VOLTAGE_WIDTH'(DEF_THRESHOLD),
   parameter int                         NUM_NEURONS       = 64,
   parameter int                         NUM_TIMESTEPS     = 4,
   localparam int                        NW = $clog2(NUM_NEURONS),
   localparam int                        TW = (NUM_TIMESTEPS > 1) ? $clog2(NUM_TIMESTEPS) : 1
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INPUT_WIDTH-1:0] in_current,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_spike,
   output logic [NW-1:0]          out_neuron_idx,
   output logic [TW-1:0]          out_timestep,
   output logic                   out_last
);

   if (NUM_NEURONS < 2) begin : g_bad_neurons
      $error("NUM_NEURONS must be at least 2");
   end
   if (NUM_TIMESTEPS < 1) begin : g_bad_timesteps
      $error("NUM_TIMESTEPS must be at least 1");
   end
   if (VOLTAGE_FRAC_BITS >= VOLTAGE_WIDTH) begin : g_bad_frac
      $error("VOLTAGE_FRAC_BITS must be smaller than VOLTAGE_WIDTH");
   end

   lif_state_t                      state;
   logic [NW-1:0]                   n;
   logic [TW-1:0]                   t;
   logic signed [VOLTAGE_WIDTH-1:0] mem [NUM_NEURONS];
   logic signed [VOLTAGE_WIDTH-1:0] v_new;
   logic                            spike;
   logic                            accept;
   logic                            take;
   logic                            last_n;
   logic                            last_t;

   assign last_n   = (n == NW'(NUM_NEURONS - 1));
   assign last_t   = (t == TW'(NUM_TIMESTEPS - 1));
   assign in_ready = (state == RUN) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign take     = out_valid && out_ready;
   assign busy     = (state != IDLE);
   assign done     = (state == DRAIN) && take && out_last;

   lif_update_core #(
      .INPUT_WIDTH   (INPUT_WIDTH),
      .VOLTAGE_WIDTH (VOLTAGE_WIDTH),
      .THRESHOLD     (THRESHOLD)
   ) u_core (
      .v_stored   (mem[n]),
      .t0         (t == {TW{1'b0}}),
      .in_current ($signed(in_current)),
      .v_new      (v_new),
      .spike      (spike)
   );

   // FSM, counters and output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         n              <= {NW{1'b0}};
         t              <= {TW{1'b0}};
         out_valid      <= 1'b0;
         out_spike      <= 1'b0;
         out_neuron_idx <= {NW{1'b0}};
         out_timestep   <= {TW{1'b0}};
         out_last       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  n     <= {NW{1'b0}};
                  t     <= {TW{1'b0}};
               end
            end
            RUN: begin
               if (accept && last_n && last_t) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (take && out_last) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (accept) begin
            out_valid      <= 1'b1;
            out_spike      <= spike;
            out_neuron_idx <= n;
            out_timestep   <= t;
            out_last       <= last_n && last_t;
            if (last_n) begin
               n <= {NW{1'b0}};
               t <= last_t ? {TW{1'b0}} : t + {{(TW-1){1'b0}}, 1'b1};
            end else begin
               n <= n + {{(NW-1){1'b0}}, 1'b1};
            end
         end else if (take) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Potential memory: no reset, stale contents are masked at t==0.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[n] <= v_new;
      end
   end

endmodule

// File: tb/tb_lif_layer_scheduler.sv
// Self-checking bench for lif_layer_scheduler (64 neurons x 4 timesteps) against an integer LIF model.
module tb_lif_layer_scheduler;

   localparam int NN   = 64;
   localparam int NT   = 4;
   localparam int THR  = 256;
   localparam int VMAX = 32767;
   localparam int VMIN = -32768;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       busy;
   logic       done;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_current;
   logic       out_valid;
   logic       out_ready;
   logic       out_spike;
   logic [5:0] out_neuron_idx;
   logic [1:0] out_timestep;
   logic       out_last;

   always #5 clk = ~clk;

   lif_layer_scheduler dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .busy           (busy),
      .done           (done),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_current     (in_current),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_spike      (out_spike),
      .out_neuron_idx (out_neuron_idx),
      .out_timestep   (out_timestep),
      .out_last       (out_last)
   );

   typedef struct {
      bit spike;
      int idx;
      int ts;
      bit last;
   } res_t;

   res_t q[$];
   int   pot[NN];
   int   mstate = 0;   // 0 idle, 1 running, 2 draining
   int   mn = 0;
   int   mt = 0;
   int   mode = 0;     // 1: expect spike exactly at t=3, 2: expect no spikes
   int   ndone = 0;
   int   ncmp = 0;
   int   nfail = 0;

   function automatic int clamp(input int x);
      if (x > VMAX) return VMAX;
      if (x < VMIN) return VMIN;
      return x;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_spike", out_spike, 1'b0);
      chk("rst_out_idx", out_neuron_idx, 6'd0);
      chk("rst_out_ts", out_timestep, 2'd0);
      chk("rst_out_last", out_last, 1'b0);
   endtask

   // One clock: drive at negedge, check settled outputs, then advance the model at posedge.
   task automatic step(input logic iv, input logic ordy, input logic [7:0] cur, input logic st);
      bit   exp_ready, take, acc, was_idle, took_last;
      res_t r;
      int   v, d;
      @(negedge clk);
      in_valid = iv; out_ready = ordy; in_current = cur; start = st;
      #1;
      exp_ready = (mstate == 1) && (q.size() == 0 || ordy);
      take      = (q.size() != 0) && ordy;
      acc       = iv && exp_ready;
      took_last = take && q[0].last;
      chk("in_ready", in_ready, exp_ready);
      chk("out_valid", out_valid, q.size() != 0);
      chk("busy", busy, mstate != 0);
      chk("done", done, took_last && mstate == 2);
      if (done === 1'b1) ndone++;
      if (q.size() != 0) begin
         chk("out_spike", out_spike, q[0].spike);
         chk("out_neuron_idx", out_neuron_idx, q[0].idx);
         chk("out_timestep", out_timestep, q[0].ts);
         chk("out_last", out_last, q[0].last);
         if (mode == 1) chk("spike_only_t3", out_spike, q[0].ts == 3);
         if (mode == 2) chk("never_spikes", out_spike, 1'b0);
      end
      was_idle = (mstate == 0);
      @(posedge clk);
      if (take) begin
         void'(q.pop_front());
         if (took_last && mstate == 2) mstate = 0;
      end
      if (acc) begin
         v      = (mt == 0) ? 0 : pot[mn];
         r.idx  = mn;
         r.ts   = mt;
         r.last = (mn == NN - 1) && (mt == NT - 1);
         if (v > THR) begin
            r.spike = 1'b1;
`ifdef LIF_SOFT_RESET_EN
            v = clamp(v - THR);
`else
            v = 0;
`endif
         end else begin
            r.spike = 1'b0;
            d = v / 4;
            if (v < 0 && (v % 4) != 0) d = d - 1;   // floor division
            v = clamp(v - d + int'($signed(cur)));
         end
         pot[mn] = v;
         q.push_back(r);
         if (r.last) mstate = 2;
         if (mn == NN - 1) begin
            mn = 0;
            mt = mt + 1;
         end else begin
            mn = mn + 1;
         end
      end
      if (was_idle && st) begin
         mstate = 1;
         mn = 0;
         mt = 0;
      end
   endtask

   // style 0: always valid/ready with fixed current; 1: output stall mid-layer; 2: random everything.
   task automatic run_inference(input int style, input logic [7:0] fixed_cur);
      int   k;
      logic iv, ordy, st;
      logic [7:0] cur;
      ndone = 0;
      step(1'b0, 1'b1, 8'h00, 1'b1);
      k = 0;
      while (mstate != 0 && k < 4000) begin
         case (style)
            0: begin iv = 1'b1; ordy = 1'b1; cur = fixed_cur; st = 1'b0; end
            1: begin iv = 1'b1; ordy = !(k >= 20 && k < 25); cur = 8'($urandom); st = 1'b0; end
            default: begin
               iv   = ($urandom_range(0, 3) != 0);
               ordy = ($urandom_range(0, 3) != 0);
               cur  = 8'($urandom);
               st   = ($urandom_range(0, 15) == 0);
            end
         endcase
         step(iv, ordy, cur, st);
         k++;
      end
      chk("inference_finished_in_budget", k < 4000, 1'b1);
      chk("done_pulse_count", ndone, 1);
      step(1'b0, 1'b1, 8'h00, 1'b0);
      chk("idle_after_done", busy, 1'b0);
   endtask

   initial begin
      int k;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_current = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs();
      @(negedge clk);
      rst = 1'b0;

      mode = 2; run_inference(0, 8'h40);
      mode = 1; run_inference(0, 8'h7F);
      mode = 2; run_inference(0, 8'h80);
      mode = 0; run_inference(1, 8'h00);
      run_inference(2, 8'h00);
      run_inference(2, 8'h00);

      // Reset while running at n=10, t=1.
      step(1'b0, 1'b1, 8'h00, 1'b1);
      k = 0;
      while (!(mn == 10 && mt == 1) && k < 200) begin
         step(1'b1, 1'b1, 8'($urandom), 1'b0);
         k++;
      end
      chk("reached_n10_t1", (mn == 10) && (mt == 1), 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_outputs();
      mstate = 0;
      q.delete();
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;

      run_inference(2, 8'h00);
      mode = 1; run_inference(0, 8'h7F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
